// File: rtl/spi_frame_assembler.sv
// Byte-to-word assembler behind the SPI slave receiver. Gathers
// BYTES_PER_WORD bytes into one word in the selected byte order and publishes
// it with a one-cycle valid strobe. A partial word is dropped, and counted as
// an error, when chip-select restarts a frame or the inter-byte timer expires.
module spi_frame_assembler #(
  parameter int BYTES_PER_WORD = 2,
  parameter int OUT_WIDTH      = 14,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  input  logic                 frame_start,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic [7:0]           err_cnt
);

  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WW = 8 * BYTES_PER_WORD;
  localparam logic [IW-1:0] LAST_IDX  = IW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [BYTES_PER_WORD-1:0][7:0] bytes_q, bytes_d;
  logic [TW-1:0]                  timer_q, timer_d;
  logic [OUT_WIDTH-1:0]           data_out_q, data_out_d;
  logic                           data_valid_q, data_valid_d;
  logic                           frame_err_q, frame_err_d;
  logic [7:0]                     err_cnt_q, err_cnt_d;

  logic [WW-1:0] word;
  logic          timeout;
  logic          start_word;
  logic          discard;

  // Place stored byte i into the word according to the configured byte order.
  always_comb begin
    word = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (MSB_FIRST) word[8*(BYTES_PER_WORD-1-i) +: 8] = bytes_q[i];
      else           word[8*i +: 8]                    = bytes_q[i];
    end
  end

  // The last idle cycle before expiry; a byte arriving in that cycle still wins.
  assign timeout = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_MAX) && !rx_done;

  // Next-state, byte capture, commit and error bookkeeping.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bytes_d      = bytes_q;
    timer_d      = timer_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_cnt_d    = err_cnt_q;
    start_word   = 1'b0;
    discard      = 1'b0;

    case (state_q)
      IDLE: begin
        start_word = rx_done;
      end
      COLLECT: begin
        if (frame_start) begin
          discard    = 1'b1;
          state_d    = IDLE;
          idx_d      = '0;
          start_word = rx_done;
        end else if (rx_done) begin
          bytes_d[idx_q] = rx_data;
          timer_d        = '0;
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (timeout) begin
          discard = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      COMMIT: begin
        data_out_d   = OUT_WIDTH'(word);
        data_valid_d = 1'b1;
        idx_d        = '0;
        state_d      = IDLE;
        start_word   = rx_done;
      end
      default: state_d = IDLE;
    endcase

    // A byte that opens a new word always lands at index 0.
    if (start_word) begin
      bytes_d[0] = rx_data;
      timer_d    = '0;
      if (BYTES_PER_WORD == 1) begin
        state_d = COMMIT;
        idx_d   = '0;
      end else begin
        state_d = COLLECT;
        idx_d   = IW'(1);
      end
    end

    if (discard) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and output registers; reset drops any partial word at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      bytes_q      <= '0;
      timer_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bytes_q      <= bytes_d;
      timer_q      <= timer_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_spi_frame_assembler.sv
// Bench for spi_frame_assembler: three configurations share one stimulus
// stream; a byte-list model predicts words and errors into per-instance
// queues that a negedge monitor drains as the DUTs pulse.
module tb_spi_frame_assembler;

  typedef struct {
    longint val;
    int     stamp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0;
  logic       frame_start = 1'b0;

  logic [13:0] a_dout;
  logic [23:0] b_dout;
  logic [7:0]  c_dout;
  logic        a_dv, b_dv, c_dv, a_fe, b_fe, c_fe;
  logic [7:0]  a_ec, b_ec, c_ec;

  logic [31:0] dout[3];
  logic        dv[3];
  logic        fe[3];
  logic [7:0]  ec[3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int     m_bpw[3] = '{2, 3, 1};
  int     m_ow[3]  = '{14, 24, 8};
  bit     m_msb[3] = '{1'b1, 1'b0, 1'b1};
  int     m_to[3]  = '{16, 0, 16};
  int     cur[3][$];
  bit     in_commit[3];
  int     idle[3];
  int     ecnt[3];
  longint last_word[3];
  exp_t   word_q[3][$];
  exp_t   err_q[3][$];
  int     valid_cnt[3];

  spi_frame_assembler #(.BYTES_PER_WORD(2), .OUT_WIDTH(14), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .frame_start(frame_start),
    .data_out(a_dout), .data_valid(a_dv), .frame_err(a_fe), .err_cnt(a_ec));

  spi_frame_assembler #(.BYTES_PER_WORD(3), .OUT_WIDTH(24), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .frame_start(frame_start),
    .data_out(b_dout), .data_valid(b_dv), .frame_err(b_fe), .err_cnt(b_ec));

  spi_frame_assembler #(.BYTES_PER_WORD(1), .OUT_WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) dut_c (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .frame_start(frame_start),
    .data_out(c_dout), .data_valid(c_dv), .frame_err(c_fe), .err_cnt(c_ec));

  assign dout[0] = {18'd0, a_dout};
  assign dout[1] = {8'd0, b_dout};
  assign dout[2] = {24'd0, c_dout};
  assign dv[0] = a_dv;
  assign dv[1] = b_dv;
  assign dv[2] = c_dv;
  assign fe[0] = a_fe;
  assign fe[1] = b_fe;
  assign fe[2] = c_fe;
  assign ec[0] = a_ec;
  assign ec[1] = b_ec;
  assign ec[2] = c_ec;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: a word is just the list of bytes received since it began.
  task automatic modelStep(input int i, input bit rx, input bit fs, input logic [7:0] d);
    bit     err = 1'b0;
    bit     accept = 1'b0;
    longint w = 0;
    if (in_commit[i] || cur[i].size() == 0) begin
      in_commit[i] = 1'b0;
      accept = rx;
    end else if (fs) begin
      err = 1'b1;
      cur[i].delete();
      accept = rx;
    end else if (rx) begin
      accept = 1'b1;
    end else begin
      idle[i]++;
      if (m_to[i] > 0 && idle[i] >= m_to[i]) begin
        err = 1'b1;
        cur[i].delete();
      end
    end
    if (accept) begin
      cur[i].push_back(int'(d));
      idle[i] = 0;
      if (cur[i].size() == m_bpw[i]) begin
        for (int k = 0; k < m_bpw[i]; k++) begin
          if (m_msb[i]) w = (w << 8) | longint'(cur[i][k]);
          else          w = w | (longint'(cur[i][k]) << (8 * k));
        end
        w = w & ((64'sd1 <<< m_ow[i]) - 1);
        word_q[i].push_back('{w, cyc + 2});
        last_word[i] = w;
        in_commit[i] = 1'b1;
        cur[i].delete();
      end
    end
    if (err) begin
      if (ecnt[i] < 255) ecnt[i]++;
      err_q[i].push_back('{longint'(ecnt[i]), cyc + 1});
    end
  endtask

  task automatic applyStimulus(input bit rx, input bit fs, input logic [7:0] d);
    @(negedge clk);
    rx_done = rx;
    frame_start = fs;
    rx_data = rx ? d : 8'd0;
    for (int i = 0; i < 3; i++) modelStep(i, rx, fs, d);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic applyReset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    rx_done = 1'b0;
    frame_start = 1'b0;
    rx_data = 8'd0;
    for (int i = 0; i < 3; i++) begin
      cur[i].delete();
      word_q[i].delete();
      err_q[i].delete();
      in_commit[i] = 1'b0;
      idle[i] = 0;
      ecnt[i] = 0;
      last_word[i] = 0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_data_out%0d", i), dout[i], 0);
      checkOutput($sformatf("reset_data_valid%0d", i), dv[i], 0);
      checkOutput($sformatf("reset_frame_err%0d", i), fe[i], 0);
      checkOutput($sformatf("reset_err_cnt%0d", i), ec[i], 0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops expectations when a DUT pulses, and flags overdue ones.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        while (word_q[i].size() > 0 && word_q[i][0].stamp < cyc) begin
          e = word_q[i].pop_front();
          checkOutput($sformatf("dut%0d_missed_valid_cycle", i), cyc, e.stamp);
        end
        while (err_q[i].size() > 0 && err_q[i][0].stamp < cyc) begin
          e = err_q[i].pop_front();
          checkOutput($sformatf("dut%0d_missed_err_cycle", i), cyc, e.stamp);
        end
        if (dv[i]) begin
          valid_cnt[i]++;
          checkOutput($sformatf("dut%0d_valid_expected", i), longint'(word_q[i].size() > 0), 1);
          if (word_q[i].size() > 0) begin
            e = word_q[i].pop_front();
            checkOutput($sformatf("dut%0d_word", i), dout[i], e.val);
            checkOutput($sformatf("dut%0d_word_cycle", i), cyc, e.stamp);
          end
        end
        if (fe[i]) begin
          checkOutput($sformatf("dut%0d_err_expected", i), longint'(err_q[i].size() > 0), 1);
          if (err_q[i].size() > 0) begin
            e = err_q[i].pop_front();
            checkOutput($sformatf("dut%0d_err_cnt", i), ec[i], e.val);
            checkOutput($sformatf("dut%0d_err_cycle", i), cyc, e.stamp);
          end
        end
      end
    end
  end

  initial begin
    int v0;
    int r;
    applyReset();

    $display("[TB] default byte order");
    applyStimulus(1'b1, 1'b0, 8'h2A);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 8'h5C);
    idleCycles(3);
    checkOutput("default_order_word", dout[0], 'h2A5C);

    $display("[TB] LSB-first three-byte word");
    applyReset();
    applyStimulus(1'b1, 1'b0, 8'h11);
    applyStimulus(1'b1, 1'b0, 8'h22);
    applyStimulus(1'b1, 1'b0, 8'h33);
    idleCycles(3);
    checkOutput("lsb_first_word", dout[1], 'h332211);

    $display("[TB] resync on frame_start");
    applyReset();
    applyStimulus(1'b1, 1'b0, 8'hAA);
    applyStimulus(1'b1, 1'b1, 8'h12);
    applyStimulus(1'b1, 1'b0, 8'h34);
    idleCycles(3);
    checkOutput("resync_word", dout[0], 'h1234);
    checkOutput("resync_err_cnt", ec[0], 1);

    $display("[TB] inter-byte timeout");
    applyReset();
    v0 = valid_cnt[0];
    applyStimulus(1'b1, 1'b0, 8'h55);
    idleCycles(18);
    checkOutput("timeout_err_cnt", ec[0], 1);
    checkOutput("timeout_no_valid", valid_cnt[0] - v0, 0);
    applyStimulus(1'b1, 1'b0, 8'h66);
    idleCycles(15);
    applyStimulus(1'b1, 1'b0, 8'h77);
    idleCycles(3);
    checkOutput("timeout_edge_word", dout[0], 'h2677);
    checkOutput("timeout_edge_err_cnt", ec[0], 1);

    $display("[TB] back-to-back bytes");
    applyReset();
    v0 = valid_cnt[0];
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 1'b0, 8'(k));
    idleCycles(3);
    checkOutput("b2b_pulses", valid_cnt[0] - v0, 4);
    checkOutput("b2b_last_word", dout[0], 'h0708);

    $display("[TB] error counter saturation");
    applyReset();
    repeat (300) begin
      applyStimulus(1'b1, 1'b0, 8'($urandom));
      applyStimulus(1'b0, 1'b1, 8'd0);
    end
    idleCycles(2);
    checkOutput("saturated_err_cnt", ec[0], 255);

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 1'b0, 8'h9A);
    applyReset();
    applyStimulus(1'b1, 1'b0, 8'hBC);
    applyStimulus(1'b1, 1'b0, 8'hDE);
    idleCycles(3);
    checkOutput("post_reset_word", dout[0], 'h3CDE);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 999));
      if (r < 20) idleCycles(int'($urandom_range(10, 20)));
      else if (r < 22) applyReset();
      else applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5, 8'($urandom));
    end

    idleCycles(5);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("dut%0d_words_left", i), word_q[i].size(), 0);
      checkOutput($sformatf("dut%0d_errs_left", i), err_q[i].size(), 0);
      checkOutput($sformatf("dut%0d_final_word", i), dout[i], last_word[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
